apb_led_pwm: RTL and testbench
==============================

# apb_led_pwm

APB3 slave peripheral on the SoC's `io_apbSlave_0` port, providing eight LED PWM channels with glitch-free duty updates and an optional debounced push-switch input with a sticky event interrupt. It sits between the SoC's APB bridge and the board LEDs/switch, replacing direct GPIO drive of `o_led`. Software programs a prescaler and eight 8-bit duty values; the block runs a free 256-step PWM frame.

## Interface
- `DEBOUNCE_CYCLES`, 500000: clocks `i_sw` must be stable before the debounced level changes (≥2).
- `io_systemClk` in 1: system clock, all logic on rising edge.
- `io_systemReset` in 1: reset; asynchronous, active-high.
- `PADDR` in 16: byte address; bits [1:0] ignored.
- `PSEL` in 1, `PENABLE` in 1, `PWRITE` in 1: APB3 control.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data, valid when `PREADY`=1.
- `PREADY` out 1: transfer completion.
- `PSLVERROR` out 1: unmapped-address error, valid when `PREADY`=1.
- `o_pwm` out 8: PWM outputs, registered.
- `o_irq` out 1: switch event interrupt, level, registered.
- `i_sw` in 1: raw switch input, asynchronous; present only with `APB_LED_PWM_DEBOUNCE_EN`.

## Operation
- Registers, offset: 0x00 CTRL {[0] EN, [1] INV, [2] IRQ_EN}; 0x04 PRESCALE [15:0]; 0x10+4·i DUTY_i [7:0], i=0..7; 0x30 SW_STAT {[0] LEVEL RO, [1] EVENT W1C}. Unused bits read 0, writes ignored.
- Any other offset: write discarded, read returns 0, `PSLVERROR`=1 in completion cycle.
- APB: SETUP (PSEL=1, PENABLE=0) → ACCESS with exactly one wait state; `PREADY`=1 in the second ACCESS cycle only. Register write and W1C take effect on that completion edge.
- Prescaler: 16-bit counter; tick every PRESCALE+1 clocks while EN=1. PRESCALE=0 → tick every clock.
- Frame counter `cnt` 8-bit, increments on tick, wraps 255→0.
- Duty written to shadow; shadow copied to active duty on the tick where cnt wraps 255→0, or immediately while EN=0.
- `o_pwm[i]` next = (cnt < active_duty[i]) XOR INV. DUTY=0 → constant low; DUTY=255 → high 255 of 256 steps.
- EN=0: prescaler and cnt held at 0, `o_pwm` = {8{INV}}. EN 0→1 starts the frame at cnt=0.
- Simultaneous DUTY write and wrap tick: active takes the OLD shadow; new value applies at the next wrap.

## Timing
- Reset values: all registers 0, cnt 0, `o_pwm`=0, `PRDATA`=0, `PREADY`=0, `PSLVERROR`=0, `o_irq`=0, debounced LEVEL=0, EVENT=0.
- `o_pwm` changes one clock after the cnt update.
- Reads: `PRDATA` is registered during the wait state and returns register state as of the first ACCESS cycle.
- Reset mid-transfer: the transfer is abandoned, with no partial write; the next transfer starts from SETUP.
- PSEL dropped without completion: the wait-state flag clears and no write occurs.

## Configuration
- `APB_LED_PWM_DEBOUNCE_EN` defined: the `i_sw` port exists.
  - 2-flop synchronizer, then a stability counter; LEVEL updates after DEBOUNCE_CYCLES consecutive equal samples.
  - A LEVEL 0→1 transition sets EVENT.
  - `o_irq` = EVENT & IRQ_EN, registered.
  - If a W1C to EVENT coincides with a new rising event, EVENT stays set.
- Not defined: no `i_sw` port. SW_STAT reads 0 with no error, IRQ_EN is stored but has no effect, and `o_irq` is tied 0.

## Structure
- Package `apb_led_pwm_pkg`: register offset constants, CTRL bit indices, channel count (8), duty width (8).
- One sub-module, `sw_debounce` (synchronizer, stability counter, rising-edge pulse, parameter DEBOUNCE_CYCLES). It is instantiated only under the macro.

## Test plan
- Reset, then read 0x00, 0x04, 0x10 → 0 each, `PREADY` exactly 2 cycles after SETUP, `PSLVERROR`=0, `o_pwm`=0.
- PRESCALE=0, DUTY0=64, DUTY1=0, DUTY2=255, EN=1 → per 256-clock frame: ch0 high 64 clocks, ch1 never high, ch2 high 255.
- During ch0 frame with DUTY0=64, write DUTY0=200 mid-frame → current frame still 64 high, next frame 200 high.
- INV=1, EN=0 → `o_pwm`=0xFF. PRESCALE=3 → cnt advances every 4 clocks.
- Read 0x40 → `PRDATA`=0, `PSLVERROR`=1; write 0x40 → no register changes.
- With the macro, DEBOUNCE_CYCLES=16, IRQ_EN=1: `i_sw` glitch of 10 clocks → LEVEL stays 0. A held high → LEVEL=1, EVENT=1, `o_irq`=1. W1C 0x30 bit1 → `o_irq`=0.

Source files
------------

// File: rtl/apb_led_pwm_pkg.sv
// Shared constants and types for the APB LED PWM peripheral: register map,
// CTRL bit positions, channel geometry and the bus-handshake state type.
package apb_led_pwm_pkg;

   localparam int NUM_CH = 8;
   localparam int DUTY_W = 8;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_INV    = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam logic [15:0] OFF_CTRL     = 16'h0000;
   localparam logic [15:0] OFF_PRESCALE = 16'h0004;
   localparam logic [15:0] OFF_DUTY0    = 16'h0010;
   localparam logic [15:0] OFF_SW_STAT  = 16'h0030;

   typedef enum logic {ST_IDLE, ST_ACK} apb_state_t;
   typedef logic [DUTY_W-1:0] duty_t;

   // Register decode works on 32-bit word indices; byte lanes are ignored.
   function automatic logic [13:0] word_of(input logic [15:0] off);
      return off[15:2];
   endfunction

endpackage

// File: rtl/apb_led_pwm_if.sv
// APB3 bus bundle between the SoC bridge (master) and the LED PWM peripheral (slave).
interface apb_led_pwm_if;
   logic [15:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERROR;

   modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
                   input  PRDATA, PREADY, PSLVERROR);
   modport slave  (input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
                   output PRDATA, PREADY, PSLVERROR);
endinterface

// File: rtl/sw_debounce.sv
// Switch conditioner: 2-flop synchronizer, stability counter, registered rising pulse.
// LEVEL follows the input after DEBOUNCE_CYCLES consecutive differing samples.
module sw_debounce
   import apb_led_pwm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
)(
   input  logic clk,
   input  logic rst,
   input  logic sw_raw,
   output logic level,
   output logic rise
);
   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          s1, s2;
   logic [CW-1:0] run;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         level <= 1'b0;
         rise  <= 1'b0;
         run   <= '0;
      end else begin
         s1   <= sw_raw;
         s2   <= s1;
         rise <= 1'b0;
         if (s2 == level) begin
            run <= '0;
         end else if (run == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= s2;
            rise  <= s2;
            run   <= '0;
         end else begin
            run <= run + CW'(1);
         end
      end
   end
endmodule

// File: rtl/apb_led_pwm.sv
// Eight-channel LED PWM APB3 slave, one wait state per transfer, 256-step frames with
// wrap-aligned duty updates. APB_LED_PWM_DEBOUNCE_EN adds the debounced switch and IRQ.
module apb_led_pwm
   import apb_led_pwm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
)(
   input  logic              io_systemClk,
   input  logic              io_systemReset,
   apb_led_pwm_if.slave      apb,
   output logic [NUM_CH-1:0] o_pwm,
   output logic              o_irq
`ifdef APB_LED_PWM_DEBOUNCE_EN
   ,
   input  logic              i_sw
`endif
);
   apb_state_t  state, state_nxt;
   logic        capture, wr_en, err_q;
   logic [2:0]  ctrl;
   logic [15:0] prescale, pcnt;
   logic [7:0]  cnt;
   duty_t       shadow [NUM_CH];
   duty_t       active [NUM_CH];
   logic        en, inv, tick, wrap;
   logic [13:0] word, duty_off;
   logic [2:0]  duty_idx;
   logic        sel_ctrl, sel_pre, sel_duty, sel_sw, mapped;
   logic [31:0] rd_dat;
   logic [1:0]  sw_stat;
   logic        unused_bits;

   assign en  = ctrl[CTRL_EN];
   assign inv = ctrl[CTRL_INV];

   assign word     = apb.PADDR[15:2];
   assign duty_off = word - word_of(OFF_DUTY0);
   assign duty_idx = duty_off[2:0];
   assign sel_ctrl = (word == word_of(OFF_CTRL));
   assign sel_pre  = (word == word_of(OFF_PRESCALE));
   assign sel_duty = (word >= word_of(OFF_DUTY0)) && (word < word_of(OFF_DUTY0) + 14'(NUM_CH));
   assign sel_sw   = (word == word_of(OFF_SW_STAT));
   assign mapped   = sel_ctrl | sel_pre | sel_duty | sel_sw;

   assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA[31:16], duty_off[13:3]} ^ (DEBOUNCE_CYCLES < 2);

   always_ff @(posedge io_systemClk or posedge io_systemReset) begin
      if (io_systemReset) state <= ST_IDLE;
      else                state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (apb.PSEL && apb.PENABLE) state_nxt = ST_ACK;
         ST_ACK:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // PREADY is qualified by PSEL so an abandoned transfer never completes.
   always_comb begin
      capture    = 1'b0;
      wr_en      = 1'b0;
      apb.PREADY = 1'b0;
      unique case (state)
         ST_IDLE: capture = apb.PSEL && apb.PENABLE;
         ST_ACK: begin
            apb.PREADY = apb.PSEL;
            wr_en      = apb.PSEL && apb.PENABLE && apb.PWRITE;
         end
         default: ;
      endcase
   end

   assign apb.PSLVERROR = err_q & apb.PREADY;

   always_comb begin
      rd_dat = '0;
      if (sel_ctrl) rd_dat[2:0]        = ctrl;
      if (sel_pre)  rd_dat[15:0]       = prescale;
      if (sel_duty) rd_dat[DUTY_W-1:0] = shadow[duty_idx];
      if (sel_sw)   rd_dat[1:0]        = sw_stat;
   end

   always_ff @(posedge io_systemClk or posedge io_systemReset) begin
      if (io_systemReset) begin
         apb.PRDATA <= '0;
         err_q      <= 1'b0;
         ctrl       <= '0;
         prescale   <= '0;
         for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      end else begin
         if (capture) begin
            apb.PRDATA <= rd_dat;
            err_q      <= !mapped;
         end
         if (wr_en) begin
            if (sel_ctrl) ctrl     <= apb.PWDATA[2:0];
            if (sel_pre)  prescale <= apb.PWDATA[15:0];
            if (sel_duty) shadow[duty_idx] <= apb.PWDATA[DUTY_W-1:0];
         end
      end
   end

   assign tick = en && (pcnt == prescale);
   assign wrap = tick && (cnt == 8'hFF);

   always_ff @(posedge io_systemClk or posedge io_systemReset) begin
      if (io_systemReset) begin
         pcnt  <= '0;
         cnt   <= '0;
         o_pwm <= '0;
         for (int i = 0; i < NUM_CH; i++) active[i] <= '0;
      end else begin
         if (!en) begin
            pcnt <= '0;
            cnt  <= '0;
         end else if (tick) begin
            pcnt <= '0;
            cnt  <= cnt + 8'd1;
         end else begin
            pcnt <= pcnt + 16'd1;
         end
         // Same-edge shadow writes land after this copy, so a wrap takes the old value.
         for (int i = 0; i < NUM_CH; i++) begin
            if (!en || wrap) active[i] <= shadow[i];
            o_pwm[i] <= en ? ((cnt < active[i]) ^ inv) : inv;
         end
      end
   end

`ifdef APB_LED_PWM_DEBOUNCE_EN
   logic sw_level, sw_rise, sw_event;

   sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_debounce (
      .clk    (io_systemClk),
      .rst    (io_systemReset),
      .sw_raw (i_sw),
      .level  (sw_level),
      .rise   (sw_rise)
   );

   always_ff @(posedge io_systemClk or posedge io_systemReset) begin
      if (io_systemReset) begin
         sw_event <= 1'b0;
         o_irq    <= 1'b0;
      end else begin
         if (sw_rise)                                 sw_event <= 1'b1;
         else if (wr_en && sel_sw && apb.PWDATA[1])   sw_event <= 1'b0;
         o_irq <= sw_event & ctrl[CTRL_IRQ_EN];
      end
   end

   assign sw_stat = {sw_event, sw_level};
`else
   assign sw_stat = '0;
   assign o_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_led_pwm.sv
// Directed bench for apb_led_pwm: APB completions are checked by a queue-driven monitor,
// PWM duty is checked by counting high cycles over aligned frames.
module tb_apb_led_pwm;
   import apb_led_pwm_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pwm;
   logic       irq;
   logic       sw = 1'b0;

   apb_led_pwm_if bus ();

   apb_led_pwm #(.DEBOUNCE_CYCLES(16)) dut (
      .io_systemClk   (clk),
      .io_systemReset (rst),
      .apb            (bus),
      .o_pwm          (pwm),
      .o_irq          (irq)
`ifdef APB_LED_PWM_DEBOUNCE_EN
      ,
      .i_sw           (sw)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_rd;
      logic [31:0] dat;
      logic        err;
      string       name;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.PREADY === 1'b1) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pready: got completion expected none");
         end else begin
            mon_e = expq.pop_front();
            chk({mon_e.name, "_err"}, 32'(bus.PSLVERROR), 32'(mon_e.err));
            if (mon_e.is_rd) chk({mon_e.name, "_rdata"}, bus.PRDATA, mon_e.dat);
         end
      end
   end

   task automatic apb(input bit wr, input logic [15:0] addr, input logic [31:0] wdat,
                      input logic [31:0] exp_dat, input logic exp_err, input string name);
      exp_t e;
      int   n;
      e.is_rd = !wr;
      e.dat   = exp_dat;
      e.err   = exp_err;
      e.name  = name;
      expq.push_back(e);
      @(posedge clk); #1;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wdat;
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.PREADY !== 1'b1 && n < 8);
      chk({name, "_lat"}, 32'(n), 32'd2);
      @(posedge clk); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
   endtask

   task automatic wr(input logic [15:0] addr, input logic [31:0] dat, input logic err, input string name);
      apb(1'b1, addr, dat, 32'h0, err, name);
   endtask

   task automatic rd(input logic [15:0] addr, input logic [31:0] exp, input logic err, input string name);
      apb(1'b0, addr, 32'h0, exp, err, name);
   endtask

   // Counts o_pwm highs per channel over n samples; call right after an enabling write.
   task automatic count_frame(input int n, output int h0, output int h1, output int h2);
      h0 = 0; h1 = 0; h2 = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         h0 += int'(pwm[0]);
         h1 += int'(pwm[1]);
         h2 += int'(pwm[2]);
      end
   endtask

   initial begin
      int h0, h1, h2, f2, f3, w;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus.PADDR = '0; bus.PWDATA = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pready", 32'(bus.PREADY), 32'd0);
      chk("rst_pslverr", 32'(bus.PSLVERROR), 32'd0);
      chk("rst_prdata", bus.PRDATA, 32'd0);
      chk("rst_pwm", 32'(pwm), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      rd(16'h0000, 32'h0, 1'b0, "rd_ctrl_rst");
      rd(16'h0004, 32'h0, 1'b0, "rd_pre_rst");
      rd(16'h0010, 32'h0, 1'b0, "rd_duty0_rst");

      wr(16'h0004, 32'hDEAD_BEEF, 1'b0, "wr_pre");
      rd(16'h0004, 32'h0000_BEEF, 1'b0, "rd_pre");
      wr(16'h001C, 32'h1234_56AB, 1'b0, "wr_duty3");
      rd(16'h001C, 32'h0000_00AB, 1'b0, "rd_duty3");
      rd(16'h001F, 32'h0000_00AB, 1'b0, "rd_duty3_lanes");
      rd(16'h002C, 32'h0, 1'b0, "rd_duty7");
      rd(16'h0008, 32'h0, 1'b1, "rd_gap");
      rd(16'h0040, 32'h0, 1'b1, "rd_unmapped");
      wr(16'h0040, 32'hFFFF_FFFF, 1'b1, "wr_unmapped");
      rd(16'h0000, 32'h0, 1'b0, "rd_ctrl_after_bad");
      rd(16'h0004, 32'h0000_BEEF, 1'b0, "rd_pre_after_bad");
      rd(16'h0010, 32'h0, 1'b0, "rd_duty0_after_bad");

      // Basic duty, then a mid-frame update that must wait for the wrap.
      wr(16'h0004, 32'd0, 1'b0, "wr_pre0");
      wr(16'h0010, 32'd64, 1'b0, "wr_d0");
      wr(16'h0014, 32'd0, 1'b0, "wr_d1");
      wr(16'h0018, 32'd255, 1'b0, "wr_d2");
      wr(16'h0000, 32'h1, 1'b0, "wr_en");
      fork
         begin
            @(posedge clk);
            count_frame(256, h0, h1, h2);
            count_frame(256, f2, w, w);
            count_frame(256, f3, w, w);
         end
         begin
            repeat (356) @(posedge clk);
            wr(16'h0010, 32'd200, 1'b0, "wr_d0_mid");
         end
      join
      chk("frame_ch0_64", 32'(h0), 32'd64);
      chk("frame_ch1_0", 32'(h1), 32'd0);
      chk("frame_ch2_255", 32'(h2), 32'd255);
      chk("frame2_ch0_old", 32'(f2), 32'd64);
      chk("frame3_ch0_new", 32'(f3), 32'd200);

      wr(16'h0000, 32'h2, 1'b0, "wr_inv_off");
      repeat (2) @(negedge clk);
      chk("inv_disabled", 32'(pwm), 32'hFF);
      wr(16'h0000, 32'h3, 1'b0, "wr_inv_en");
      @(posedge clk);
      count_frame(256, h0, h1, h2);
      chk("inv_ch0", 32'(h0), 32'd56);
      chk("inv_ch1", 32'(h1), 32'd256);
      chk("inv_ch2", 32'(h2), 32'd1);

      wr(16'h0000, 32'h0, 1'b0, "wr_dis");
      wr(16'h0004, 32'd3, 1'b0, "wr_pre3");
      wr(16'h0010, 32'd1, 1'b0, "wr_d0_1");
      wr(16'h0014, 32'd2, 1'b0, "wr_d1_2");
      wr(16'h0000, 32'h1, 1'b0, "wr_en_pre3");
      @(posedge clk);
      count_frame(1024, h0, h1, h2);
      chk("pre3_ch0", 32'(h0), 32'd4);
      chk("pre3_ch1", 32'(h1), 32'd8);
      chk("pre3_ch2", 32'(h2), 32'd1020);
      wr(16'h0000, 32'h0, 1'b0, "wr_dis2");

`ifdef APB_LED_PWM_DEBOUNCE_EN
      wr(16'h0000, 32'h4, 1'b0, "wr_irq_en");
      @(posedge clk); #1 sw = 1'b1;
      repeat (10) @(posedge clk);
      #1 sw = 1'b0;
      repeat (20) @(posedge clk);
      rd(16'h0030, 32'h0, 1'b0, "rd_sw_glitch");
      chk("irq_glitch", 32'(irq), 32'd0);
      #1 sw = 1'b1;
      repeat (40) @(posedge clk);
      rd(16'h0030, 32'h3, 1'b0, "rd_sw_event");
      chk("irq_set", 32'(irq), 32'd1);
      wr(16'h0030, 32'h2, 1'b0, "wr_w1c");
      repeat (2) @(negedge clk);
      chk("irq_clr", 32'(irq), 32'd0);
      rd(16'h0030, 32'h1, 1'b0, "rd_sw_after_w1c");
`else
      wr(16'h0000, 32'h4, 1'b0, "wr_irq_en");
      rd(16'h0000, 32'h4, 1'b0, "rd_irq_en");
      rd(16'h0030, 32'h0, 1'b0, "rd_sw_stat");
      repeat (2) @(negedge clk);
      chk("irq_tied", 32'(irq), 32'd0);
`endif

      // PSEL dropped after the wait state: no completion, no write.
      wr(16'h0010, 32'h11, 1'b0, "wr_d0_known");
      @(posedge clk); #1;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 16'h0010; bus.PWDATA = 32'h77;
      @(posedge clk); #1 bus.PENABLE = 1'b1;
      @(posedge clk); #1 begin bus.PSEL = 1'b0; bus.PENABLE = 1'b0; end
      repeat (3) @(posedge clk);
      rd(16'h0010, 32'h11, 1'b0, "rd_d0_abandoned");

      // Reset in the wait state abandons the write.
      @(posedge clk); #1;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 16'h0014; bus.PWDATA = 32'h99;
      @(posedge clk); #1 bus.PENABLE = 1'b1;
      #2 rst = 1'b1;
      @(posedge clk); #1 begin bus.PSEL = 1'b0; bus.PENABLE = 1'b0; end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_pwm", 32'(pwm), 32'd0);
      rd(16'h0014, 32'h0, 1'b0, "rd_d1_after_rst");

      w = 0;
      while (expq.size() != 0 && w < 20) begin
         @(posedge clk);
         w++;
      end
      chk("queue_drained", 32'(expq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
